main_lcd_sequencer: RTL and testbench
=====================================

MAIN_LCD_SEQUENCER -- requirements
Module: main_lcd_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: reset is sampled only on the rising edge of clk.
REQ-002 Parameters SHALL be:
- PWR_CYC, default 750000: power-up wait of 15 ms at 50 MHz.
- SETUP_CYC, default 2: RS/data setup time before EN rises.
- EN_CYC, default 25: EN high width.
- HOLD_CYC, default 2: data hold time after EN falls.
- EXEC_CYC, default 2500: normal command execution wait.
- LONG_CYC, default 82000: clear/home execution wait.
- FIFO_DEPTH, default 4: number of queued writes.
REQ-003 The ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data.
- lcd_data  out  8  HD44780 data bus.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_rw  out  1  tied to 0 (write-only).
- lcd_en  out  1  enable strobe.
- busy  out  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-004 A write occurs when chipselect=1 and write_n=0. The register map SHALL be:
- Address 0: enqueue {rs=0, writedata[7:0]} (command).
- Address 1: enqueue {rs=1, writedata[7:0]} (data).
- Address 2: write ignored.
- Address 3: writing writedata[0]=1 clears the overflow flag.
REQ-005 readdata SHALL be decoded from address alone; reads have no side effects:
- Address 2: {25'b0, count[2:0], 1'b0, overflow, full, busy}.
- All other addresses: 0.
REQ-006 The FIFO SHALL hold 9-bit entries {rs, byte}. A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-007 A rejected push SHALL set the sticky overflow flag and leave the FIFO unchanged.
REQ-008 FSM states SHALL be PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-009 PWR_WAIT SHALL last PWR_CYC cycles, then go to INIT with init index 0.
REQ-010 INIT SHALL load the init-ROM entry {0, byte} into the output latch and go to SETUP. The ROM sequence is 0x38, 0x0C, 0x01, 0x06.
REQ-011 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the output latch and go to SETUP in the same cycle.
REQ-012 lcd_data and lcd_rs SHALL be driven from the latch from the first SETUP cycle and SHALL remain stable through HOLD and EXEC.
REQ-013 Phase timing SHALL be:
- SETUP: SETUP_CYC cycles, lcd_en=0.
- PULSE: EN_CYC cycles, lcd_en=1.
- HOLD: HOLD_CYC cycles, lcd_en=0.
- lcd_en SHALL be registered and glitch-free.
REQ-014 EXEC SHALL wait LONG_CYC cycles when rs=0 and byte is in 0x01..0x03. It SHALL wait EXEC_CYC cycles otherwise.
REQ-015 On EXEC expiry the FSM SHALL go to INIT if init is incomplete (index < 4, after incrementing the index). Otherwise it SHALL go to IDLE.
REQ-016 The EXEC-to-IDLE transition SHALL NOT pop; a queued entry is popped on the first IDLE cycle. The minimum gap between EN pulses is therefore HOLD_CYC + EXEC + 1 + SETUP_CYC cycles.
REQ-017 Host writes SHALL be accepted into the FIFO during PWR_WAIT and INIT. They SHALL be issued only after the init sequence completes.
REQ-018 All phase counters SHALL be wide enough for max(PWR_CYC, LONG_CYC) and SHALL reload on every state entry. Each phase SHALL last exactly its parameter value in cycles.

Reset
REQ-019 While reset=1, outputs SHALL be: lcd_en=0, lcd_data=0, lcd_rs=0, lcd_rw=0.
REQ-020 While reset=1, internal state SHALL be: FIFO empty, overflow=0, FSM=PWR_WAIT, init index=0.
REQ-021 A reset asserted mid-PULSE SHALL drive lcd_en low on the next clock edge, discard all queued entries, and restart the power-up sequence.

Structure
REQ-022 Package main_lcd_pkg SHALL hold:
- the FSM state enum,
- the register address constants,
- the init-ROM constants,
- the long-command byte range.
REQ-023 The FIFO SHALL be a sub-module, main_lcd_fifo: parameterised depth and width, synchronous, exposing a count output. The FSM and register decode SHALL live in main_lcd_sequencer.

Verification
REQ-024 The bench SHALL use PWR_CYC=20, SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, LONG_CYC=40, FIFO_DEPTH=4.
REQ-025 Directed scenarios SHALL be:
- Init: release reset, no writes -> four EN pulses with rs=0 and data 0x38, 0x0C, 0x01, 0x06. The first EN rises at cycle 20+1+2. The gap after 0x01 reflects the 40-cycle wait. busy falls after the last EXEC.
- Data/command ordering: after init, write address1=0x41 then address0=0x80 -> EN pulses with {rs=1, 0x41} then {rs=0, 0x80}. Each EN is high exactly 4 cycles; data is stable from 2 cycles before EN rises to 2 cycles after it falls.
- Overflow: during PWR_WAIT write 5 data bytes -> status full=1, overflow=1, count=4. Only the first 4 bytes are issued. Writing address3=1 clears overflow.
- Simultaneous push and pop: FIFO full in IDLE, write on the pop cycle -> push accepted, overflow stays 0, count stays 4.
- Long command: after init, enqueue 0x02 then 0x41 -> the EN rise-to-rise gap is 4+2+40+1+2 cycles.
- Reset mid-PULSE: assert reset while lcd_en=1 -> lcd_en=0 on the next edge, status count=0, init sequence replays from 0x38.

Source files
------------

// File: rtl/main_lcd_pkg.sv
// main_lcd_pkg: shared states, register map and init ROM for the LCD sequencer
package main_lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int INIT_LEN = 4;

  // 8-bit bus, 2 lines; display on; clear; entry mode increment
  function automatic logic [7:0] init_byte(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
  endfunction

  // clear and return-home commands need the long execution wait
  localparam logic [7:0] LONG_LO = 8'h01;
  localparam logic [7:0] LONG_HI = 8'h03;

endpackage

// File: rtl/main_lcd_fifo.sv
// main_lcd_fifo: synchronous FIFO that accepts a push on a full cycle when a pop frees a slot
module main_lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rp];

  // storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_data;

  // pointer and occupancy tracking
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end

endmodule

// File: rtl/main_lcd_sequencer.sv
// main_lcd_sequencer: Avalon-fed HD44780 write sequencer with power-up init
import main_lcd_pkg::*;

module main_lcd_sequencer #(
  parameter int PWR_CYC    = 750000,
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 25,
  parameter int HOLD_CYC   = 2,
  parameter int EXEC_CYC   = 2500,
  parameter int LONG_CYC   = 82000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy
);

  localparam int MAX_CYC = PWR_CYC > LONG_CYC ? PWR_CYC : LONG_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int FW      = $clog2(FIFO_DEPTH + 1);

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0] lat, lat_n, head;
  logic [2:0] idx, idx_n;
  logic [FW-1:0] count;
  logic wr, push, pop, full, empty, overflow, en, is_long;
  logic unused_bits;

  assign wr          = chipselect && !write_n;
  assign push        = wr && (address == ADDR_CMD || address == ADDR_DATA);
  assign is_long     = !lat[8] && lat[7:0] >= LONG_LO && lat[7:0] <= LONG_HI;
  assign unused_bits = ^writedata[31:8];

  main_lcd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data ({address == ADDR_DATA, writedata[7:0]}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // next state: each phase counter reloads to its length minus one on entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CW'(1);
    lat_n   = lat;
    idx_n   = idx;
    pop     = 1'b0;
    case (state)
      PWR_WAIT: if (cnt == '0) state_n = INIT;
      INIT: begin
        lat_n   = {1'b0, init_byte(idx[1:0])};
        state_n = SETUP;
        cnt_n   = CW'(SETUP_CYC - 1);
      end
      IDLE: if (!empty) begin
        pop     = 1'b1;
        lat_n   = head;
        state_n = SETUP;
        cnt_n   = CW'(SETUP_CYC - 1);
      end
      SETUP: if (cnt == '0) begin
        state_n = PULSE;
        cnt_n   = CW'(EN_CYC - 1);
      end
      PULSE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = CW'(HOLD_CYC - 1);
      end
      HOLD: if (cnt == '0) begin
        state_n = EXEC;
        cnt_n   = is_long ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
      end
      EXEC: if (cnt == '0) begin
        idx_n   = idx < 3'(INIT_LEN) ? idx + 3'd1 : idx;
        state_n = idx_n < 3'(INIT_LEN) ? INIT : IDLE;
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // state, latch and a registered enable so lcd_en never glitches on decode
  always_ff @(posedge clk)
    if (reset) begin
      state    <= PWR_WAIT;
      cnt      <= CW'(PWR_CYC - 1);
      lat      <= '0;
      idx      <= '0;
      en       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat      <= lat_n;
      idx      <= idx_n;
      en       <= state_n == PULSE;
      overflow <= (wr && address == ADDR_CTRL && writedata[0]) ? 1'b0 :
                  (push && full && !pop) ? 1'b1 : overflow;
    end

  assign lcd_data = lat[7:0];
  assign lcd_rs   = lat[8];
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en;
  assign busy     = state != IDLE || !empty;
  assign readdata = address == ADDR_STATUS ?
                    {25'b0, 3'(count), 1'b0, overflow, full, busy} : 32'b0;

endmodule

// File: tb/tb_main_lcd_sequencer.sv
// tb_main_lcd_sequencer: scoreboard bench for the LCD sequencer
module tb_main_lcd_sequencer;

  logic clk, reset, chipselect, write_n;
  logic [1:0] address;
  logic [31:0] writedata, readdata;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, busy;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cur = 0;

  main_lcd_sequencer #(
    .PWR_CYC(20), .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2),
    .EXEC_CYC(10), .LONG_CYC(40), .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_status(input string n, input logic [31:0] x);
    address = 2'd2;
    #1;
    chk(n, readdata, x);
  endtask

  task automatic expect_pulse(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs  = rs;
    e.d   = d;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_init();
    expect_pulse(1'b0, 8'h38, 0);
    expect_pulse(1'b0, 8'h0C, 19);
    expect_pulse(1'b0, 8'h01, 19);
    expect_pulse(1'b0, 8'h06, 49);
  endtask

  task automatic init_check();
    int fe;
    bit done;
    fe   = -1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (lcd_en && fe < 0) fe = cur;
      if (!busy) done = 1'b1;
      else step();
    end
    chk("first_en_cycle", 32'(fe), 32'd23);
    chk("busy_fall_cycle", 32'(cur), 32'd126);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) step();
    chk("idle_reached", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
  endtask

  // monitor: on every EN rise pop the expected word; track width and bus stability
  initial begin
    logic en_p;
    logic [8:0] h1, h2, cap, cv;
    int w, hold;
    bit trk, ok;
    time tp;
    exp_t e;
    en_p = 1'b0;
    h1 = '0;
    h2 = '0;
    cap = '0;
    w = 0;
    hold = 0;
    trk = 1'b0;
    ok = 1'b0;
    tp = 0;
    forever begin
      @(negedge clk);
      cv = {lcd_rs, lcd_data};
      if (lcd_en && !en_p) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=%0h required=none", cv);
        end else begin
          e = q.pop_front();
          chk("pulse_word", 32'(cv), 32'({e.rs, e.d}));
          if (e.gap != 0) chk("pulse_gap", 32'(($time - tp) / 10), 32'(e.gap));
        end
        tp   = $time;
        cap  = cv;
        ok   = (h1 == cap) && (h2 == cap);
        w    = 1;
        trk  = 1'b1;
        hold = 0;
      end else if (lcd_en && trk) begin
        w++;
        ok = ok && (cv == cap);
      end else if (!lcd_en && en_p && trk) begin
        if (!reset) chk("en_width", 32'(w), 32'd4);
        ok   = ok && (cv == cap);
        hold = 1;
        trk  = 1'b0;
      end else if (hold > 0) begin
        ok = ok && (cv == cap);
        hold--;
        if (hold == 0) chk("data_stable", 32'(ok), 32'd1);
      end
      if (reset) begin
        trk  = 1'b0;
        hold = 0;
      end
      en_p = lcd_en;
      h2   = h1;
      h1   = cv;
    end
  end

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    repeat (3) step();
    chk("rst_lcd_en", 32'(lcd_en), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    rd_status("rst_status", 32'h01);
    address = 2'd0;
    #1;
    chk("read_addr0", readdata, 32'h0);

    push_init();
    reset = 1'b0;
    cur = 0;
    init_check();
    chk("scoreboard_after_init", 32'(q.size()), 32'd0);
    rd_status("idle_status", 32'h00);

    expect_pulse(1'b1, 8'h41, 0);
    expect_pulse(1'b0, 8'h80, 19);
    wr(2'd1, 32'h41);
    wr(2'd0, 32'h80);
    wait_idle();

    expect_pulse(1'b0, 8'h02, 0);
    expect_pulse(1'b1, 8'h41, 49);
    wr(2'd0, 32'h02);
    wr(2'd1, 32'h41);
    wait_idle();

    reset = 1'b1;
    repeat (2) step();
    push_init();
    expect_pulse(1'b1, 8'h61, 19);
    expect_pulse(1'b1, 8'h62, 19);
    expect_pulse(1'b1, 8'h63, 19);
    expect_pulse(1'b1, 8'h64, 19);
    expect_pulse(1'b1, 8'h66, 19);
    reset = 1'b0;
    cur = 0;
    for (int i = 0; i < 5; i++) wr(2'd1, 32'(8'h61 + i));
    rd_status("overflow_status", 32'h47);
    wr(2'd2, 32'h99);
    rd_status("addr2_write_ignored", 32'h47);
    wr(2'd3, 32'h1);
    rd_status("overflow_cleared", 32'h43);
    while (cur < 126) step();
    wr(2'd1, 32'h66);
    rd_status("push_on_pop", 32'h43);
    wait_idle();

    expect_pulse(1'b1, 8'h55, 0);
    wr(2'd1, 32'h55);
    wr(2'd1, 32'h56);
    wr(2'd1, 32'h57);
    for (int i = 0; i < 100 && !lcd_en; i++) step();
    chk("en_seen", 32'(lcd_en), 32'd1);
    reset = 1'b1;
    step();
    chk("midpulse_lcd_en", 32'(lcd_en), 32'd0);
    chk("midpulse_lcd_data", 32'(lcd_data), 32'd0);
    chk("midpulse_lcd_rs", 32'(lcd_rs), 32'd0);
    rd_status("midpulse_status", 32'h01);
    step();
    push_init();
    reset = 1'b0;
    cur = 0;
    init_check();
    rd_status("final_status", 32'h00);
    repeat (5) step();
    chk("scoreboard_final", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
